// File: rtl/vector_issue_scheduler_pkg.sv
// Shared types and constants for the vector issue scheduler.
package vector_issue_scheduler_pkg;

    // Functional-unit encodings carried in to_vector.fu
    localparam logic [1:0] INT_FU = 2'd0;
    localparam logic [1:0] FP_FU  = 2'd1;
    localparam logic [1:0] MEM_FU = 2'd2;
    localparam logic [1:0] FXP_FU = 2'd3;

    // Bit positions in the per-unit ready/done/valid vectors
    localparam int INT_IDX = 0;
    localparam int FP_IDX  = 1;
    localparam int MEM_IDX = 2;

    // Microop encoding used by the front end for a bubble
    localparam logic [6:0] BUBBLE_UOP = 7'h7F;

    typedef struct packed {
        logic [1:0] fu;
        logic [6:0] microop;
        logic       reconfigure;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
    } to_vector;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RECONF = 2'd2
    } sched_state_e;

endpackage

// File: rtl/vector_issue_scheduler_fifo.sv
// Instruction FIFO: registered head, no empty bypass, full ignores same-cycle pop.
module vector_instr_fifo
    import vector_issue_scheduler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  to_vector                 data_i,
    input  logic                     pop_i,
    output to_vector                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    to_vector      mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Storage is cleared on reset so the shared head output is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_issue_scheduler.sv
// In-order issue scheduler: routes FIFO head to INT/FP/MEM with an outstanding-op
// limit per unit, drains all units before a reconfigure, drops illegal encodings.
module vector_issue_scheduler
    import vector_issue_scheduler_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    output logic       ready_o,
    input  to_vector   instr_in,
    output to_vector   issue_instr_o,
    output logic       int_valid_o,
    output logic       fp_valid_o,
    output logic       mem_valid_o,
    input  logic [2:0] fu_ready_i,
    input  logic [2:0] fu_done_i,
    output logic       reconfig_valid_o,
    output logic       illegal_o,
    output logic       busy_o
);
    localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUTSTANDING);

    logic                 fifo_full, fifo_empty, push, pop;
    logic [AW:0]          fifo_count;
    to_vector             head;
    sched_state_e         state_q, state_d;
    logic [2:0][CW-1:0]   cnt_q, cnt_d;
    logic [2:0]           unit_valid, fire, cnt_nz;
    logic                 head_ill, head_rec, all_idle, illegal, reconfig;

    assign ready_o = !fifo_full;
    assign push    = valid_in && ready_o;

    vector_instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (instr_in),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign head_ill = !fifo_empty && ((head.fu == FXP_FU) || (head.microop == BUBBLE_UOP));
    assign head_rec = !fifo_empty && head.reconfigure && !head_ill;
    assign fire     = unit_valid & fu_ready_i;
    assign all_idle = (cnt_nz == 3'b000);

    // Per-unit "has outstanding work" flags from the registered counters.
    always_comb begin
        cnt_nz = '0;
        for (int u = 0; u < 3; u++) begin
            cnt_nz[u] = (cnt_q[u] != '0);
        end
    end

    // Next state and issue decisions; at most one unit valid per cycle.
    always_comb begin
        state_d    = state_q;
        unit_valid = '0;
        pop        = 1'b0;
        illegal    = 1'b0;
        reconfig   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (head_ill) begin
                    illegal = 1'b1;
                    pop     = 1'b1;
                end else if (head_rec) begin
                    state_d = ST_DRAIN;
                end else if (!fifo_empty) begin
                    case (head.fu)
                        INT_FU:  unit_valid[INT_IDX] = (cnt_q[INT_IDX] < CNT_MAX);
                        FP_FU:   unit_valid[FP_IDX]  = (cnt_q[FP_IDX]  < CNT_MAX);
                        MEM_FU:  unit_valid[MEM_IDX] = (cnt_q[MEM_IDX] < CNT_MAX);
                        default: unit_valid = '0;
                    endcase
                    pop = |(unit_valid & fu_ready_i);
                end
            end
            ST_DRAIN: begin
                if (all_idle) begin
                    state_d = ST_RECONF;
                end
            end
            ST_RECONF: begin
                reconfig = !fifo_empty;
                pop      = !fifo_empty;
                state_d  = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Outstanding counters: issue and completion in the same cycle cancel;
    // a completion with nothing outstanding is ignored.
    always_comb begin
        cnt_d = cnt_q;
        for (int u = 0; u < 3; u++) begin
            if (fire[u] && !(fu_done_i[u] && cnt_nz[u])) begin
                cnt_d[u] = cnt_q[u] + 1'b1;
            end else if (!fire[u] && fu_done_i[u] && cnt_nz[u]) begin
                cnt_d[u] = cnt_q[u] - 1'b1;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign issue_instr_o    = head;
    assign int_valid_o      = unit_valid[INT_IDX];
    assign fp_valid_o       = unit_valid[FP_IDX];
    assign mem_valid_o      = unit_valid[MEM_IDX];
    assign reconfig_valid_o = reconfig;
    assign illegal_o        = illegal;
    assign busy_o           = (fifo_count != '0) || !all_idle;

    a_done_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        (fu_done_i & ~cnt_nz) == 3'b000);
    a_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(unit_valid));

endmodule

// File: tb/tb_vector_issue_scheduler.sv
// Directed bench for vector_issue_scheduler with hand-computed expectations.
module tb_vector_issue_scheduler;
    import vector_issue_scheduler_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0;
    to_vector   instr_in = '0;
    logic [2:0] fu_ready_i = 3'b000;
    logic [2:0] fu_done_i = 3'b000;
    logic       ready_o;
    to_vector   issue_instr_o;
    logic       int_valid_o, fp_valid_o, mem_valid_o;
    logic       reconfig_valid_o, illegal_o, busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vector_issue_scheduler #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .ready_o          (ready_o),
        .instr_in         (instr_in),
        .issue_instr_o    (issue_instr_o),
        .int_valid_o      (int_valid_o),
        .fp_valid_o       (fp_valid_o),
        .mem_valid_o      (mem_valid_o),
        .fu_ready_i       (fu_ready_i),
        .fu_done_i        (fu_done_i),
        .reconfig_valid_o (reconfig_valid_o),
        .illegal_o        (illegal_o),
        .busy_o           (busy_o)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_units(input string tag, input logic [2:0] exp);
        check_val(tag, 32'({mem_valid_o, fp_valid_o, int_valid_o}), 32'(exp));
    endtask

    function automatic to_vector mk(input logic [1:0] fu, input logic [6:0] uop, input logic rec);
        to_vector v;
        v             = '0;
        v.fu          = fu;
        v.microop     = uop;
        v.reconfigure = rec;
        v.vd          = uop[4:0];
        v.vs1         = 5'd3;
        v.vs2         = 5'd7;
        return v;
    endfunction

    logic [6:0] t2_head  [5] = '{7'h10, 7'h11, 7'h12, 7'h13, 7'h14};
    logic       t2_ready [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        #1;
        check_val("rst_ready", 32'(ready_o), 1);
        check_val("rst_busy", 32'(busy_o), 0);
        chk_units("rst_units", 3'b000);
        check_val("rst_illegal", 32'(illegal_o), 0);
        check_val("rst_reconfig", 32'(reconfig_valid_o), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: single INT op, issue and completion
        fu_ready_i = 3'b111;
        valid_in   = 1'b1;
        instr_in   = mk(INT_FU, 7'h01, 1'b0);
        tick();
        valid_in = 1'b0;
        chk_units("t1_issue", 3'b001);
        check_val("t1_head", 32'(issue_instr_o.microop), 'h01);
        tick();
        chk_units("t1_after", 3'b000);
        check_val("t1_busy", 32'(busy_o), 1);
        fu_done_i = 3'b001;
        tick();
        fu_done_i = 3'b000;
        check_val("t1_idle", 32'(busy_o), 0);

        // 2: fill FIFO while units stall, then drain in order
        fu_ready_i = 3'b000;
        for (int k = 0; k < 4; k++) begin
            valid_in = 1'b1;
            instr_in = mk(INT_FU, 7'(16 + k), 1'b0);
            check_val("t2_accept", 32'(ready_o), 1);
            tick();
        end
        instr_in = mk(INT_FU, 7'h14, 1'b0);
        check_val("t2_full", 32'(ready_o), 0);
        chk_units("t2_blocked", 3'b001);
        tick();
        check_val("t2_full_hold", 32'(ready_o), 0);
        fu_ready_i = 3'b111;
        for (int i = 0; i < 5; i++) begin
            fu_done_i = (i > 0) ? 3'b001 : 3'b000;
            if (i == 2) valid_in = 1'b0;
            check_val("t2_ready", 32'(ready_o), 32'(t2_ready[i]));
            chk_units("t2_issue", 3'b001);
            check_val("t2_order", 32'(issue_instr_o.microop), 32'(t2_head[i]));
            tick();
        end
        fu_done_i = 3'b001;
        tick();
        fu_done_i = 3'b000;
        check_val("t2_idle", 32'(busy_o), 0);

        // 3: MEM outstanding limit
        valid_in = 1'b1;
        instr_in = mk(MEM_FU, 7'h20, 1'b0);
        tick();
        instr_in = mk(MEM_FU, 7'h21, 1'b0);
        chk_units("t3_first", 3'b100);
        check_val("t3_head0", 32'(issue_instr_o.microop), 'h20);
        tick();
        instr_in = mk(MEM_FU, 7'h22, 1'b0);
        chk_units("t3_second", 3'b100);
        check_val("t3_head1", 32'(issue_instr_o.microop), 'h21);
        tick();
        valid_in = 1'b0;
        chk_units("t3_hold", 3'b000);
        check_val("t3_head2", 32'(issue_instr_o.microop), 'h22);
        tick();
        fu_done_i = 3'b100;
        chk_units("t3_hold_done", 3'b000);
        tick();
        fu_done_i = 3'b000;
        chk_units("t3_third", 3'b100);
        tick();
        chk_units("t3_after", 3'b000);
        fu_done_i = 3'b100;
        tick();
        tick();
        fu_done_i = 3'b000;
        check_val("t3_idle", 32'(busy_o), 0);

        // 4: reconfigure drains the INT unit first
        valid_in = 1'b1;
        instr_in = mk(INT_FU, 7'h30, 1'b0);
        tick();
        instr_in = mk(INT_FU, 7'h31, 1'b0);
        chk_units("t4_int0", 3'b001);
        tick();
        instr_in = mk(INT_FU, 7'h40, 1'b1);
        chk_units("t4_int1", 3'b001);
        tick();
        instr_in = mk(FP_FU, 7'h32, 1'b0);
        chk_units("t4_rec_head", 3'b000);
        check_val("t4_rec_flag", 32'(issue_instr_o.reconfigure), 1);
        check_val("t4_no_pulse0", 32'(reconfig_valid_o), 0);
        tick();
        valid_in = 1'b0;
        chk_units("t4_drain", 3'b000);
        check_val("t4_no_pulse1", 32'(reconfig_valid_o), 0);
        tick();
        fu_done_i = 3'b001;
        tick();
        check_val("t4_no_pulse2", 32'(reconfig_valid_o), 0);
        tick();
        fu_done_i = 3'b000;
        check_val("t4_drain_zero", 32'(reconfig_valid_o), 0);
        tick();
        check_val("t4_pulse", 32'(reconfig_valid_o), 1);
        check_val("t4_pulse_uop", 32'(issue_instr_o.microop), 'h40);
        chk_units("t4_pulse_units", 3'b000);
        tick();
        check_val("t4_pulse_end", 32'(reconfig_valid_o), 0);
        chk_units("t4_fp", 3'b010);
        check_val("t4_fp_uop", 32'(issue_instr_o.microop), 'h32);
        tick();
        fu_done_i = 3'b010;
        tick();
        fu_done_i = 3'b000;
        check_val("t4_idle", 32'(busy_o), 0);

        // 5: FXP and bubble dropped, then INT issues
        valid_in = 1'b1;
        instr_in = mk(FXP_FU, 7'h01, 1'b0);
        tick();
        instr_in = mk(INT_FU, BUBBLE_UOP, 1'b0);
        check_val("t5_ill_fxp", 32'(illegal_o), 1);
        chk_units("t5_units0", 3'b000);
        tick();
        instr_in = mk(INT_FU, 7'h50, 1'b0);
        check_val("t5_ill_bubble", 32'(illegal_o), 1);
        chk_units("t5_units1", 3'b000);
        tick();
        valid_in = 1'b0;
        check_val("t5_ill_end", 32'(illegal_o), 0);
        chk_units("t5_int", 3'b001);
        check_val("t5_int_uop", 32'(issue_instr_o.microop), 'h50);
        tick();
        fu_done_i = 3'b001;
        tick();
        fu_done_i = 3'b000;
        check_val("t5_idle", 32'(busy_o), 0);

        // 6: asynchronous reset during DRAIN with a full FIFO
        valid_in = 1'b1;
        instr_in = mk(INT_FU, 7'h60, 1'b0);
        tick();
        instr_in = mk(INT_FU, 7'h41, 1'b1);
        tick();
        instr_in = mk(FP_FU, 7'h61, 1'b0);
        tick();
        instr_in = mk(FP_FU, 7'h62, 1'b0);
        tick();
        instr_in = mk(FP_FU, 7'h63, 1'b0);
        tick();
        valid_in = 1'b0;
        check_val("t6_full", 32'(ready_o), 0);
        chk_units("t6_drain_units", 3'b000);
        check_val("t6_busy", 32'(busy_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_ready", 32'(ready_o), 1);
        check_val("t6_rst_busy", 32'(busy_o), 0);
        chk_units("t6_rst_units", 3'b000);
        check_val("t6_rst_reconfig", 32'(reconfig_valid_o), 0);
        check_val("t6_rst_illegal", 32'(illegal_o), 0);
        check_val("t6_rst_head", 32'(issue_instr_o), 0);
        tick();
        tick();
        rst_n = 1'b1;
        check_val("t6_rel_ready", 32'(ready_o), 1);
        for (int i = 0; i < 5; i++) begin
            check_val("t6_no_reconfig", 32'(reconfig_valid_o), 0);
            check_val("t6_no_busy", 32'(busy_o), 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
